// File: rtl/fpga_apb_arbiter.sv
// Two-requester APB arbiter in front of a single APB completer.
// Round-robin between the host bridge (m0) and the fuse/debug engine (m1),
// with a forced-completion timeout for completers that never respond.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transfer owned; arbitrate any asserted mN_psel
// SETUP   | s_psel=1, s_penable=0 for the granted requester (1 cycle)
// ACCESS  | s_psel=1, s_penable=1 until s_pready or the timeout fires
module fpga_apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int USER_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              core_clk,
  input  logic              cptra_rst_b,

  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic [USER_W-1:0] m0_pauser,
  input  logic [2:0]        m0_pprot,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pready,
  output logic              m0_pslverr,

  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  input  logic [USER_W-1:0] m1_pauser,
  input  logic [2:0]        m1_pprot,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pready,
  output logic              m1_pslverr,

  output logic              s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [DATA_W-1:0] s_pwdata,
  output logic [USER_W-1:0] s_pauser,
  output logic [2:0]        s_pprot,
  input  logic [DATA_W-1:0] s_prdata,
  input  logic              s_pready,
  input  logic              s_pslverr,

  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Completion is forced on the ACCESS cycle where the count equals this.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_err_q, timeout_err_d;

  logic        any_req;
  logic        winner;
  logic        in_access;
  logic        done_ok;
  logic        done_to;
  logic        resp_ready;
  logic        resp_err;
  logic [DATA_W-1:0] resp_data;
  logic        active;

  // The requester's own penable carries no information the arbiter needs:
  // the arbiter generates the completer-side phases itself.
  logic        unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_req = m0_psel | m1_psel;
    winner  = 1'b0;
    if (m0_psel && m1_psel) begin
      winner = ~last_grant_q;
    end else if (m1_psel) begin
      winner = 1'b1;
    end
  end

  // Completion qualifiers; a real pready beats the timeout on the threshold cycle.
  always_comb begin
    in_access = (state_q == ST_ACCESS);
    done_ok   = in_access && s_pready;
    done_to   = in_access && !s_pready && (cnt_q == TO_LAST);
  end

  // State, grant, round-robin history, timeout counter and sticky error.
  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = 16'd0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done_ok || done_to) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          if (done_to) begin
            timeout_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Completer-side request mux; everything is held at zero while idle.
  always_comb begin
    active    = (state_q != ST_IDLE);
    s_psel    = active;
    s_penable = in_access;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    s_pauser  = '0;
    s_pprot   = 3'b000;
    if (active) begin
      if (grant_q) begin
        s_pwrite = m1_pwrite;
        s_paddr  = m1_paddr;
        s_pwdata = m1_pwdata;
        s_pauser = m1_pauser;
        s_pprot  = m1_pprot;
      end else begin
        s_pwrite = m0_pwrite;
        s_paddr  = m0_paddr;
        s_pwdata = m0_pwdata;
        s_pauser = m0_pauser;
        s_pprot  = m0_pprot;
      end
    end
  end

  // Requester-side response steering; only the granted side ever sees a response.
  always_comb begin
    resp_ready = done_ok | done_to;
    resp_err   = done_ok ? s_pslverr : done_to;
    resp_data  = done_ok ? s_prdata : '0;

    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m0_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    m1_prdata  = '0;
    if (resp_ready) begin
      if (grant_q) begin
        m1_pready  = 1'b1;
        m1_pslverr = resp_err;
        m1_prdata  = resp_data;
      end else begin
        m0_pready  = 1'b1;
        m0_pslverr = resp_err;
        m0_prdata  = resp_data;
      end
    end
  end

  assign grant       = grant_q;
  assign busy        = active;
  assign timeout_err = timeout_err_q;

endmodule
